// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : audio_pkg
//  Description : Shared constants and the stereo sample-pair type for the
//                codec serial transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
package audio_pkg;

    // Bits per channel sample; the codec only supports 16.
    localparam int SAMPLE_W = 16;

    // Frame divider: 512 clk per frame, 32 slots of 16 clk.
    localparam int DIV_W = 9;
    localparam logic [DIV_W-1:0] FRAME_LAST = 9'd511;

    // First slot of each channel within a frame.
    localparam int LEFT_FIRST_SLOT  = 0;
    localparam int RIGHT_FIRST_SLOT = 16;

    // Left occupies the upper half so the packed pair is already in wire order.
    typedef struct packed {
        logic [SAMPLE_W-1:0] left;
        logic [SAMPLE_W-1:0] right;
    } stereo_pair_t;

endpackage
`default_nettype wire

// File: rtl/i2s_frame_tx_if.sv
`default_nettype none
// ============================================================================
//  Interface   : i2s_frame_tx_if
//  Description : Sample-pair valid/ready handshake between the volume stage
//                (master) and the serial transmitter (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface i2s_frame_tx_if;
    import audio_pkg::*;

    logic [SAMPLE_W-1:0] sample_left;
    logic [SAMPLE_W-1:0] sample_right;
    logic                sample_valid;
    logic                sample_ready;

    modport master (
        output sample_left,
        output sample_right,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_left,
        input  sample_right,
        input  sample_valid,
        output sample_ready
    );

endinterface
`default_nettype wire

// File: rtl/i2s_clkgen.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_clkgen
//  Description : Free-running 9-bit frame divider. Codec clocks are taken
//                straight from divider bits so they cannot glitch; also
//                provides the per-slot and per-frame strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_clkgen
    import audio_pkg::*;
(
    input  wire logic clk,
    input  wire logic rst,          // synchronous, active-low
    output logic      audio_mclk,
    output logic      audio_sck,
    output logic      audio_lrck,
    output logic      bit_strobe,   // last clk of a slot
    output logic      frame_load,   // last clk of a frame
    output logic      frame_start   // first clk of a frame
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    // Next divider value: count up and wrap to zero after the last frame clk.
    always_comb begin
        div_d = div_q + DIV_W'(1);
        if (div_q == FRAME_LAST) begin
            div_d = '0;
        end
    end

    // Divider register; reset parks it at the start of a frame.
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign audio_mclk = div_q[1];
    assign audio_sck  = div_q[3];
    assign audio_lrck = div_q[8];

    assign bit_strobe = (div_q[3:0] == 4'hF);
    assign frame_load = (div_q == FRAME_LAST);
    // Gated by rst so the pulse is suppressed while reset is held, yet fires
    // on the very first cycle after release.
    assign frame_start = rst && (div_q == '0);

endmodule
`default_nettype wire

// File: rtl/i2s_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_frame_tx
//  Description : Serializes one stereo 16-bit pair per 512-clk frame onto the
//                codec serial interface. One-deep holding buffer behind a
//                valid/ready handshake; a sticky flag records any frame that
//                found the buffer empty.
//  Config      : I2S_DELAY_EN defined   -> standard I2S framing (MSB one slot
//                                          after the lrck edge)
//                I2S_DELAY_EN undefined -> left-justified framing
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_frame_tx
    import audio_pkg::*;
(
    input  wire logic      clk,
    input  wire logic      rst,         // synchronous, active-low
    i2s_frame_tx_if.slave  smp,
    output logic           audio_mclk,
    output logic           audio_sck,
    output logic           audio_lrck,
    output logic           audio_sdin,
    output logic           frame_start,
    output logic           underrun
);

    localparam int WORD_W = 2 * SAMPLE_W;

    logic bit_strobe;
    logic frame_load;

    i2s_clkgen u_clkgen (
        .clk         (clk),
        .rst         (rst),
        .audio_mclk  (audio_mclk),
        .audio_sck   (audio_sck),
        .audio_lrck  (audio_lrck),
        .bit_strobe  (bit_strobe),
        .frame_load  (frame_load),
        .frame_start (frame_start)
    );

    stereo_pair_t        hold_q,     hold_d;
    logic                full_q,     full_d;
    logic                ready_q,    ready_d;
    logic [WORD_W-1:0]   shift_q,    shift_d;
    logic                sdin_q,     sdin_d;
    logic                underrun_q, underrun_d;
    logic                accept;
    logic [WORD_W-1:0]   load_word;

    assign accept = smp.sample_valid && ready_q;

    // Buffer management, frame load and bit shifting for the next cycle.
    always_comb begin
        hold_d     = hold_q;
        full_d     = full_q;
        shift_d    = shift_q;
        sdin_d     = sdin_q;
        underrun_d = underrun_q;
        load_word  = '0;

        // The load looks at the buffer as it stood before this cycle's
        // handshake, so a pair arriving on the load cycle waits a frame.
        if (frame_load) begin
            if (full_q) begin
                load_word = hold_q;
                full_d    = 1'b0;
            end else begin
                underrun_d = 1'b1;
            end
        end

        if (accept) begin
            hold_d.left  = smp.sample_left;
            hold_d.right = smp.sample_right;
            full_d       = 1'b1;
        end

        ready_d = ~full_d;

        // sdin only moves on the last clk of a slot, i.e. while sck is low.
        if (frame_load) begin
`ifdef I2S_DELAY_EN
            // The bit left over from the previous word fills slot 0.
            sdin_d  = shift_q[WORD_W-1];
            shift_d = load_word;
`else
            sdin_d  = load_word[WORD_W-1];
            shift_d = {load_word[WORD_W-2:0], 1'b0};
`endif
        end else if (bit_strobe) begin
            sdin_d  = shift_q[WORD_W-1];
            shift_d = {shift_q[WORD_W-2:0], 1'b0};
        end
    end

    // State registers; reset abandons any frame in progress.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_q     <= '0;
            full_q     <= 1'b0;
            ready_q    <= 1'b1;
            shift_q    <= '0;
            sdin_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            full_q     <= full_d;
            ready_q    <= ready_d;
            shift_q    <= shift_d;
            sdin_q     <= sdin_d;
            underrun_q <= underrun_d;
        end
    end

    assign smp.sample_ready = ready_q;
    assign audio_sdin       = sdin_q;
    assign underrun         = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2s_frame_tx
//  Description : Self-checking bench for i2s_frame_tx. A frame-level model
//                (queue of one pending pair, per-frame 32-bit bit sequence)
//                predicts every output on every clk.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_frame_tx;

    logic clk = 1'b0;
    logic rst;
    logic audio_mclk, audio_sck, audio_lrck, audio_sdin, frame_start, underrun;

    i2s_frame_tx_if bus ();

    i2s_frame_tx dut (
        .clk         (clk),
        .rst         (rst),
        .smp         (bus),
        .audio_mclk  (audio_mclk),
        .audio_sck   (audio_sck),
        .audio_lrck  (audio_lrck),
        .audio_sdin  (audio_sdin),
        .frame_start (frame_start),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    // One record per frame: pair to offer (and when), and the 32 bits the
    // frame itself must carry in each framing mode.
    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        int          send_at;
        logic [31:0] exp_lj;
        logic [31:0] exp_i2s;
    } frame_vec_t;

    frame_vec_t tbl [11];

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    int          m_t;         // position within frame, 0..511
    logic        m_full;      // a pair is waiting
    logic [31:0] m_hold;      // {left,right} waiting
    logic        m_underrun;
    logic [31:0] m_seq;       // bits of the frame now on the wire, slot 0 = [31]
    logic        m_prev_lsb;  // right LSB of the frame now on the wire
    logic        last_acc;
    int          dut_acc;

    function automatic logic [31:0] frame_bits(input logic [31:0] p);
`ifdef I2S_DELAY_EN
        return {m_prev_lsb, p[31:1]};
`else
        return p;
`endif
    endfunction

    task automatic model_reset();
        m_t        = 0;
        m_full     = 1'b0;
        m_hold     = '0;
        m_underrun = 1'b0;
        m_seq      = '0;
        m_prev_lsb = 1'b0;
    endtask

    task automatic chk_bit(input string what, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at div %0d: got %b, expected %b", what, m_t, act, exp);
        end
    endtask

    task automatic chk32(input string what, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s #%0d: got %h, expected %h", what, idx, act, exp);
        end
    endtask

    task automatic check_outputs();
        int slot;
        slot = m_t / 16;
        chk_bit("mclk",        audio_mclk,       ((m_t / 2) % 2) == 1);
        chk_bit("sck",         audio_sck,        ((m_t / 8) % 2) == 1);
        chk_bit("lrck",        audio_lrck,       m_t >= 256);
        chk_bit("sdin",        audio_sdin,       m_seq[31 - slot]);
        chk_bit("frame_start", frame_start,      rst && (m_t == 0));
        chk_bit("ready",       bus.sample_ready, !m_full);
        chk_bit("underrun",    underrun,         m_underrun);
    endtask

    // Advance the model across one clk edge using the inputs now applied,
    // then compare every output in the new cycle.
    task automatic tick();
        logic        acc;
        logic [31:0] pair;
        acc = 1'b0;
        if (!rst) begin
            model_reset();
        end else begin
            acc = bus.sample_valid && !m_full;
            if (bus.sample_valid && bus.sample_ready) dut_acc++;
            if (m_t == 511) begin
                if (m_full) begin
                    pair = m_hold;
                end else begin
                    pair       = '0;
                    m_underrun = 1'b1;
                end
                m_seq      = frame_bits(pair);
                m_prev_lsb = pair[0];
                m_full     = 1'b0;
            end
            if (acc) begin
                m_hold = {bus.sample_left, bus.sample_right};
                m_full = 1'b1;
            end
            m_t = (m_t + 1) % 512;
        end
        last_acc = acc;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    // Run one whole frame from div 0, optionally offering a pair for one clk,
    // and capture sdin/lrck at each sck rise.
    task automatic run_frame(input logic [15:0] l, input logic [15:0] r, input int send_at,
                             output logic [31:0] bits, output logic [31:0] ws);
        bits = '0;
        ws   = '0;
        for (int i = 0; i < 512; i++) begin
            bus.sample_valid = (i == send_at);
            bus.sample_left  = l;
            bus.sample_right = r;
            tick();
            if (m_t % 16 == 8) begin
                bits[31 - m_t / 16] = audio_sdin;
                ws[31 - m_t / 16]   = audio_lrck;
            end
        end
        bus.sample_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] bits, ws, exp;
        logic [15:0] cnt;
        int          rst_at;

        tbl[0]  = '{16'hA5C3, 16'h0F01,  100, 32'h00000000, 32'h00000000};
        tbl[1]  = '{16'hA5C3, 16'h0F01,  100, 32'hA5C30F01, 32'h52E18780};
        tbl[2]  = '{16'h8000, 16'h0001,  100, 32'hA5C30F01, 32'hD2E18780};
        tbl[3]  = '{16'hFFFF, 16'hFFFE,  250, 32'h80000001, 32'hC0000000};
        tbl[4]  = '{16'h0000, 16'h0000,  300, 32'hFFFFFFFE, 32'hFFFFFFFF};
        tbl[5]  = '{16'h1234, 16'h8765,  510, 32'h00000000, 32'h00000000};
        tbl[6]  = '{16'h0000, 16'h0000,   -1, 32'h12348765, 32'h091A43B2};
        tbl[7]  = '{16'hC001, 16'h0003,  511, 32'h00000000, 32'h80000000};
        tbl[8]  = '{16'h0000, 16'h0000,   -1, 32'h00000000, 32'h00000000};
        tbl[9]  = '{16'h0000, 16'h0000,   -1, 32'hC0010003, 32'h60008001};
        tbl[10] = '{16'h0000, 16'h0000,   -1, 32'h00000000, 32'h80000000};

        // Reset held for 5 clk, outputs checked every cycle
        rst              = 1'b0;
        bus.sample_valid = 1'b0;
        bus.sample_left  = '0;
        bus.sample_right = '0;
        dut_acc          = 0;
        model_reset();
        repeat (5) tick();
        rst = 1'b1;
        #1;
        check_outputs();

        // Table-driven frames: back-to-back pairs, underrun, boundary handshake
        for (int k = 0; k < 11; k++) begin
            run_frame(tbl[k].l, tbl[k].r, tbl[k].send_at, bits, ws);
`ifdef I2S_DELAY_EN
            exp = tbl[k].exp_i2s;
`else
            exp = tbl[k].exp_lj;
`endif
            chk32("frame_bits", k, bits, exp);
            chk32("frame_lrck", k, ws, 32'h0000FFFF);
        end
        chk_bit("underrun_sticky", underrun, 1'b1);

        // Backpressure: valid held high, one acceptance per frame
        cnt              = 16'h0100;
        bus.sample_valid = 1'b1;
        bus.sample_left  = cnt;
        bus.sample_right = ~cnt;
        for (int f = 0; f < 4; f++) begin
            dut_acc = 0;
            for (int i = 0; i < 512; i++) begin
                tick();
                if (last_acc) begin
                    cnt              = cnt + 16'd1;
                    bus.sample_left  = cnt;
                    bus.sample_right = ~cnt;
                end
            end
            chk32("accepts_per_frame", f, 32'(dut_acc), 32'd1);
        end

        // Random traffic with a mid-frame reset
        rst_at = $urandom_range(600, 1800);
        for (int c = 0; c < 2560; c++) begin
            bus.sample_valid = ($urandom_range(0, 39) == 0);
            bus.sample_left  = 16'($urandom);
            bus.sample_right = 16'($urandom);
            if (c == rst_at) rst = 1'b0;
            tick();
            if (c == rst_at + 2) begin
                rst = 1'b1;
                #1;
                check_outputs();
            end
        end
        bus.sample_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2s_frame_tx.md
# i2s_frame_tx

Serializes stereo 16-bit PCM samples onto the codec serial interface (MCLK/SCK/LRCK/SDIN). It sits directly downstream of the note generator and volume stage. It accepts one left/right sample pair per audio frame through a valid/ready handshake and double-buffers that pair. It derives all codec clocks from the system clock with a single free-running divider.

## Interface
- SAMPLE_W, 16, bits per channel sample. Fixed at 16 for the codec; other values are unsupported.
- clk  in  1  system clock (100 MHz crystal).
- rst  in  1  reset; synchronous, active-low.
- sample_left  in  16  left-channel sample, two's complement.
- sample_right  in  16  right-channel sample, two's complement.
- sample_valid  in  1  the sample pair is valid this cycle.
- sample_ready  out  1  the holding buffer is empty and can accept a pair.
- audio_mclk  out  1  master clock, clk/4.
- audio_sck  out  1  bit clock, clk/16.
- audio_lrck  out  1  word select, clk/512; 0 = left, 1 = right.
- audio_sdin  out  1  serial data, MSB first.
- frame_start  out  1  one-cycle pulse at the first clk of each frame.
- underrun  out  1  sticky flag; a frame boundary found the holding buffer empty.

## Operation
- 9-bit divider `div` counts 0..511 and wraps to 0.
  - audio_mclk = div[1]; audio_sck = div[3]; audio_lrck = div[8].
  - All four codec outputs are registers or direct counter bits. No combinational glitches.
- Slot index is div[8:4], 0..31. Slots 0–15 carry the left channel; slots 16–31 carry the right channel.
- Each slot lasts 16 clk. audio_sdin changes only while audio_sck is low, on the cycle where div[3:0] wraps 15→0, so it is stable across the sck rising edge.
- Holding buffer: 32-bit {left,right} plus a full flag.
  - sample_valid && sample_ready captures the pair and sets full.
  - sample_ready = ~full, registered.
- Frame load happens on the cycle with div == 511:
  - If full: shift register ← holding buffer, and full is cleared.
  - If empty: shift register ← 0, and underrun is set to 1.
  - underrun stays 1 until reset.
- Simultaneous handshake and load at div == 511 with the buffer empty:
  - The pair is captured into the holding buffer.
  - The frame about to start still transmits zeros and flags underrun.
  - The captured pair is sent in the following frame.
- Handshake at div == 511 with the buffer full is impossible, because ready is low.
- frame_start = 1 when div == 0.
- Reset (rst == 0 at a clk edge) clears everything; a mid-frame reset abandons the frame immediately. Values during and after reset:
  - div = 0.
  - audio_mclk, audio_sck, audio_lrck, audio_sdin = 0.
  - sample_ready = 1.
  - underrun = 0.
  - frame_start = 0 while rst is low; once rst is released, the first frame begins with div = 0 and frame_start pulses on that cycle.
  - Holding buffer and shift register = 0.

## Timing
- Frame period is 512 clk (195.3 kHz at 100 MHz). One pair is consumed per frame.
- Latency: a pair accepted in frame N (at or before div == 510) is transmitted in frame N+1. Its left MSB appears on audio_sdin while div ∈ [0,15] of frame N+1.
- sample_ready falls on the cycle after acceptance. It rises at div == 0 after the load.
- The first frame after reset always transmits zeros. It does not flag underrun, because no load preceded it.

## Configuration
- I2S_DELAY_EN defined: standard I2S framing.
  - The MSB of each channel is delayed one slot after the lrck edge.
  - Slot 0 carries the previous frame's right LSB.
  - Slot 16 carries the left LSB.
  - After reset, the carried bit is 0.
- I2S_DELAY_EN undefined: left-justified framing. The MSB is aligned with the lrck edge: slot 0 = left[15], slot 16 = right[15].

## Structure
- Package `audio_pkg`:
  - SAMPLE_W
  - DIV_W = 9
  - FRAME_LAST = 9'd511
  - slot constants LEFT_FIRST_SLOT = 0, RIGHT_FIRST_SLOT = 16
  - the stereo pair typedef (struct of left/right logic [15:0])
- Sub-module `i2s_clkgen`: owns the divider, the codec clock outputs, and the strobes `bit_strobe` (div[3:0] == 15), `frame_load` (div == 511) and `frame_start`.
- The top level holds the handshake, holding buffer, shift register and underrun flag.

## Test plan
- Reset: hold rst low for 5 clk, then release. Check that all outputs hold their reset values during reset, frame_start pulses on the first cycle after release, sample_ready = 1, and audio_sdin = 0 for the whole first frame.
- Left-justified mode: present left = 16'hA5C3, right = 16'h0F01 with valid at div = 100 of frame 0. In frame 1, check that sampling audio_sdin at each sck rise gives 1010010111000011 then 0000111100000001, with lrck = 0 for the first 16 bits and 1 for the last 16.
- I2S_DELAY_EN: send the same pair twice back to back. Check that frame 1 slot 0 = 0 and slot 1 = 1. Check that frame 2 slot 0 = 1, the previous right LSB.
- Underrun: accept no pair during frame 1. Check that frame 2 is all zeros and underrun = 1 from div == 0 of frame 2, staying set after later valid pairs.
- Boundary handshake: assert valid at div == 511 with the buffer empty. Check that the next frame is zeros with underrun set, and that the pair appears in the frame after it.
- Backpressure: hold valid high continuously with an incrementing pair. Check that exactly one pair is accepted per 512 clk and that ready is low from acceptance until div == 0.
